// File: rtl/riscv_rf_pkg.sv
// Shared register-file types and sizing helpers.
package riscv_rf_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    // Address width for a register bank of n entries (at least one bit).
    function automatic int unsigned addr_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef logic [addr_w(NREGS_DEF)-1:0] reg_addr_t;
    typedef logic [XLEN_DEF-1:0]          xword_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: issue sets, writeback clears, set wins on the same edge.
module rf_scoreboard
    import riscv_rf_pkg::*;
#(
    parameter int unsigned NREGS   = NREGS_DEF,
    parameter int unsigned NUM_WR  = 1,
    parameter int unsigned ZERO_R0 = 1,
    localparam int unsigned AW     = addr_w(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic                   sb_set_en,
    input  logic [AW-1:0]          sb_set_addr,
    output logic [NREGS-1:0]       busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;

    // Decode set/clear requests and resolve the next busy state.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        busy_d  = busy_q;
        if (sb_set_en) begin
            set_vec[sb_set_addr] = 1'b1;
        end
        for (int p = 0; p < int'(NUM_WR); p++) begin
            if (wr_en[p]) begin
                clr_vec[wr_addr[p*AW +: AW]] = 1'b1;
            end
        end
        for (int r = 0; r < int'(NREGS); r++) begin
            if (set_vec[r]) begin
                busy_d[r] = 1'b1;
            end else if (clr_vec[r]) begin
                busy_d[r] = 1'b0;
            end
        end
        if (ZERO_R0 != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Busy array register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-to-read bypass and per-register scoreboard.
module regfile_mp_sb
    import riscv_rf_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned NREGS   = NREGS_DEF,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned NUM_WR  = 1,
    parameter int unsigned ZERO_R0 = 1,
    parameter int unsigned REG_RD  = 0,
    localparam int unsigned AW     = addr_w(NREGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*XLEN-1:0]   wr_data,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     sb_set_en,
    input  logic [AW-1:0]            sb_set_addr,
    output logic [NREGS-1:0]         busy_vec
);

    logic [XLEN-1:0]        mem_q [NREGS];
    logic [XLEN-1:0]        mem_d [NREGS];
    logic [NUM_RD*XLEN-1:0] byp_data;
    logic [NUM_RD-1:0]      byp_busy;

    // Merge write ports into next storage state; ascending loop lets the highest port win.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < int'(NUM_WR); p++) begin
            if (wr_en[p] && !((ZERO_R0 != 0) && (wr_addr[p*AW +: AW] == AW'(0)))) begin
                mem_d[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
            end
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < int'(NREGS); r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    // Read bypass: a write landing this cycle forwards its data and retires the busy flag.
    always_comb begin
        byp_data = '0;
        byp_busy = '0;
        for (int q = 0; q < int'(NUM_RD); q++) begin
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] val;
            logic            hit;
            ra  = rd_addr[q*AW +: AW];
            val = mem_q[ra];
            hit = 1'b0;
            for (int p = 0; p < int'(NUM_WR); p++) begin
                if (wr_en[p] && (wr_addr[p*AW +: AW] == ra)) begin
                    val = wr_data[p*XLEN +: XLEN];
                    hit = 1'b1;
                end
            end
            if ((ZERO_R0 != 0) && (ra == AW'(0))) begin
                val = '0;
            end
            byp_data[q*XLEN +: XLEN] = val;
            byp_busy[q]              = busy_vec[ra] && !hit;
        end
    end

    generate
        if (REG_RD != 0) begin : g_rd_reg
            logic [NUM_RD*XLEN-1:0] rd_data_q;
            logic [NUM_RD-1:0]      rd_busy_q;

            // Registered read path: bypassed value visible one cycle later.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q <= '0;
                    rd_busy_q <= '0;
                end else begin
                    rd_data_q <= byp_data;
                    rd_busy_q <= byp_busy;
                end
            end

            assign rd_data = rd_data_q;
            assign rd_busy = rd_busy_q;
        end else begin : g_rd_comb
            assign rd_data = byp_data;
            assign rd_busy = byp_busy;
        end
    endgenerate

    rf_scoreboard #(
        .NREGS   (NREGS),
        .NUM_WR  (NUM_WR),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .busy_vec    (busy_vec)
    );

endmodule
